// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - FSM state type, frame constants and frame builder for the SPI controller
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_write_controller_if.sv
// rtl/spi_write_controller_if.sv - host request and SPI pin bundle
// SPI_CTRL_READ_EN adds rw, cipo and rdata.
interface spi_write_controller_if;
  import spi_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              ncs;
  logic              copi;
`ifdef SPI_CTRL_READ_EN
  logic              rw;
  logic              cipo;
  logic [DATA_W-1:0] rdata;
`endif

  // master is the host plus the SPI target; slave is the controller
  modport master (
    output start, addr, wdata,
`ifdef SPI_CTRL_READ_EN
    output rw, cipo,
    input  rdata,
`endif
    input  busy, done, sclk, ncs, copi
  );

  modport slave (
    input  start, addr, wdata,
`ifdef SPI_CTRL_READ_EN
    input  rw, cipo,
    output rdata,
`endif
    output busy, done, sclk, ncs, copi
  );

endinterface

// File: rtl/spi_ctrl_tick.sv
// rtl/spi_ctrl_tick.sv - half-period tick, one pulse every DIV_HALF cycles while enabled
module spi_ctrl_tick #(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_write_controller.sv
// rtl/spi_write_controller.sv - 16-bit SPI mode-0 register write controller
// Optional read path (rw, cipo, rdata) under macro SPI_CTRL_READ_EN.
module spi_write_controller
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DIV_HALF = 4
) (
  input logic                   clk,
  input logic                   rst,
  spi_write_controller_if.slave bus
);

  state_t             state;
  state_t             state_next;
  logic               tick;
  logic               rise;
  logic               fall;
  logic               last_bit;
  logic               sclk_q;
  logic               frame_rw;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;

`ifdef SPI_CTRL_READ_EN
  assign frame_rw = bus.rw;
`else
  assign frame_rw = 1'b1;
`endif

  // tick counter restarts on every IDLE exit, so SHIFT always begins with a full low phase
  spi_ctrl_tick #(.DIV_HALF(DIV_HALF)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  assign rise     = (state == ST_SHIFT) && tick && !sclk_q;
  assign fall     = (state == ST_SHIFT) && tick && sclk_q;
  assign last_bit = (bit_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b1;
    bus.ncs    = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        bus.ncs  = 1'b1;
        if (bus.start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall && last_bit) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) state_next = ST_GAP;
      end
      ST_GAP: begin
        bus.ncs  = 1'b1;
        bus.done = tick;
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // the shift register drains to zero, leaving copi low once the frame is out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == ST_IDLE) begin
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      if (bus.start) shreg <= build_frame(frame_rw, bus.addr, bus.wdata);
    end else begin
      if (rise) sclk_q <= 1'b1;
      if (fall) begin
        sclk_q <= 1'b0;
        shreg  <= {shreg[FRAME_W-2:0], 1'b0};
        if (!last_bit) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign bus.sclk = sclk_q;
  assign bus.copi = shreg[FRAME_W-1];

`ifdef SPI_CTRL_READ_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rise && bit_cnt >= 4'd8) begin
      rdata_q <= {rdata_q[DATA_W-2:0], bus.cipo};
    end
  end

  assign bus.rdata = rdata_q;
`endif

endmodule

// File: doc/spi_write_controller.md
SPI_WRITE_CONTROLLER -- requirements
Module: spi_write_controller

Interface
REQ-001 SHALL have parameter DIV_HALF, default 4: clk cycles per SCLK half-period; legal values are 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: transaction request, sampled only while busy=0.
REQ-005 SHALL have port addr, input, 7 bits: target register address, frame bits 14:8.
REQ-006 SHALL have port wdata, input, 8 bits: write data, frame bits 7:0.
REQ-007 SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a transaction completes.
REQ-009 SHALL have port sclk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-010 SHALL have port ncs, output, 1 bit: active-low chip select.
REQ-011 SHALL have port copi, output, 1 bit: controller-out data line, MSB first.

Function
REQ-012 SHALL form a 16-bit frame {rw, addr, wdata}; bit 15 (rw) is 1 for a write.
REQ-013 SHALL implement states IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-014 In IDLE, start=1 SHALL latch the frame and enter SHIFT on the next cycle, with ncs=0, sclk=0, copi=bit 15, busy=1.
REQ-015 SHIFT SHALL produce 16 SCLK periods, each DIV_HALF cycles low then DIV_HALF cycles high.
REQ-016 copi SHALL change only while sclk is low, and is stable across every rising edge.
REQ-017 After the 16th falling edge, the FSM SHALL enter HOLD for DIV_HALF cycles with ncs=0 and sclk=0.
REQ-018 Total ncs-low time SHALL be 33*DIV_HALF cycles.
REQ-019 GAP SHALL hold ncs=1 for DIV_HALF cycles; done pulses for one cycle on the last GAP cycle, and busy falls on the cycle after.
REQ-020 start while busy=1 SHALL be ignored and not queued; start held high in IDLE on the cycle after busy falls begins a new transaction.
REQ-021 The latched frame SHALL be unaffected by changes on addr/wdata during a transaction.
REQ-022 A bit counter SHALL count 0..15 with no wrap; the transition out of SHIFT occurs exactly at count 15's falling edge.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, sclk=0, ncs=1, copi=0, busy=0, done=0, and clear all counters, including mid-transaction.
REQ-024 After a mid-transaction reset, no done pulse and no further SCLK edges SHALL occur until a new start.

Configuration
REQ-025 Macro SPI_CTRL_READ_EN SHALL, when defined, add input rw (1 bit, frame bit 15), input cipo (1 bit), and output rdata (8 bits).
REQ-026 With SPI_CTRL_READ_EN, rdata SHALL capture cipo on the rising edges of frame bits 7..0, MSB first.
REQ-027 With SPI_CTRL_READ_EN, rdata SHALL be valid from the done cycle, hold until the next capture, and reset to 0x00.
REQ-028 Without SPI_CTRL_READ_EN, those ports and logic SHALL be absent and frame bit 15 is fixed at 1 (write-only).

Structure
REQ-029 Package spi_ctrl_pkg SHALL hold the FSM state enum and the constants FRAME_W=16, ADDR_W=7, DATA_W=8.
REQ-030 Sub-module spi_ctrl_tick SHALL generate a one-cycle half-period tick every DIV_HALF cycles while enabled, restarting at 0 when enabled.

Verification
REQ-031 Write test: DIV_HALF=4, addr=0x00, wdata=0xF0 -> copi sampled on rising edges = 1000_0000_1111_0000; 16 rising edges; ncs low 132 cycles; exactly one done pulse.
REQ-032 Start-while-busy test: pulse start mid-SHIFT with addr=0x7F -> frame unchanged, single done pulse, no second transaction.
REQ-033 Reset test: assert rst after the 5th rising edge -> same cycle ncs=1, sclk=0, busy=0; no done pulse; a following write of 0x02/0x55 completes correctly.
REQ-034 Minimum-divider test: DIV_HALF=1, addr=0x04, wdata=0x80 -> SCLK period 2 cycles; ncs low 33 cycles; correct bits.
REQ-035 Back-to-back test: start held high -> two full transactions separated by a DIV_HALF-cycle ncs-high gap.
REQ-036 Read test (SPI_CTRL_READ_EN): rw=0, addr=0x03, responder drives 0xA5 on bits 7..0 -> frame bit 15 = 0; rdata=0xA5 at done.
